// File: rtl/demux_reg_bank_8x8.sv
// demux_reg_bank_8x8: 8-entry register bank behind the SAP demux, with round-robin dirty drain port
module demux_reg_bank_8x8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [2:0]       sel,
  input  logic             wr,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic [WIDTH-1:0] q5,
  output logic [WIDTH-1:0] q6,
  output logic [WIDTH-1:0] q7,
  output logic [7:0]       dirty,
  output logic             drain_valid,
  input  logic             drain_ready,
  output logic [2:0]       drain_idx,
  output logic [WIDTH-1:0] drain_data
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];
  logic [WIDTH-1:0] lanes  [8];
  logic [7:0]       dirty_q, dirty_d;
  logic [2:0]       ptr_q, ptr_d, idx_q, idx_d, pick;
  logic [WIDTH-1:0] data_q, data_d;
  logic             found;
  assign lanes = '{in0, in1, in2, in3, in4, in5, in6, in7};
  // first dirty entry at or after ptr, wrapping modulo 8
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    for (int i = 0; i < 8; i++) begin
      if (!found && dirty_q[ptr_q + 3'(i)]) begin
        found = 1'b1;
        pick  = ptr_q + 3'(i);
      end
    end
  end
  // the write is applied last so a same-edge set beats the drain clear
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    data_d  = data_q;
    dirty_d = dirty_q;
    regs_d  = regs_q;
    if (state_q == IDLE && found) begin
      dirty_d[pick] = 1'b0;
      idx_d         = pick;
      data_d        = regs_q[pick];
      state_d       = PRESENT;
    end
    if (state_q == PRESENT && drain_ready) begin
      ptr_d   = idx_q + 3'd1;
      state_d = IDLE;
    end
    if (wr) begin
      regs_d[sel]  = lanes[sel];
      dirty_d[sel] = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      regs_q  <= '{default: '0};
      dirty_q <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      dirty_q <= dirty_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end
  assign {q7, q6, q5, q4, q3, q2, q1, q0} =
    {regs_q[7], regs_q[6], regs_q[5], regs_q[4], regs_q[3], regs_q[2], regs_q[1], regs_q[0]};
  assign dirty       = dirty_q;
  assign drain_valid = (state_q == PRESENT);
  assign drain_idx   = idx_q;
  assign drain_data  = data_q;
endmodule

// File: tb/tb_demux_reg_bank_8x8.sv
// tb_demux_reg_bank_8x8: directed vector table plus hand sequences for the drain corner cases
module tb_demux_reg_bank_8x8;
  logic       clk = 1'b0, rst = 1'b0, wr = 1'b0, drain_ready = 1'b0;
  logic [2:0] sel = '0;
  logic [7:0] lanes [8];
  logic [7:0] qo [8];
  logic [7:0] dirty, drain_data;
  logic       drain_valid;
  logic [2:0] drain_idx;
  logic [7:0] mq [8];
  int         n_cmp = 0, n_bad = 0;
  demux_reg_bank_8x8 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in0(lanes[0]), .in1(lanes[1]), .in2(lanes[2]), .in3(lanes[3]),
    .in4(lanes[4]), .in5(lanes[5]), .in6(lanes[6]), .in7(lanes[7]),
    .sel(sel), .wr(wr),
    .q0(qo[0]), .q1(qo[1]), .q2(qo[2]), .q3(qo[3]),
    .q4(qo[4]), .q5(qo[5]), .q6(qo[6]), .q7(qo[7]),
    .dirty(dirty), .drain_valid(drain_valid), .drain_ready(drain_ready),
    .drain_idx(drain_idx), .drain_data(drain_data)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic       rb;
    logic       w;
    logic [2:0] s;
    logic [7:0] d;
    logic       r;
    logic [7:0] ed;
    logic       ev;
    logic [2:0] ei;
    logic [7:0] edata;
  } vec_t;
  vec_t tv [17];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic check(input string n, input logic [7:0] ed, input logic ev,
                       input logic [2:0] ei, input logic [7:0] edata);
    chk({n, ".dirty"}, 64'(dirty), 64'(ed));
    chk({n, ".valid"}, 64'(drain_valid), 64'(ev));
    chk({n, ".idx"}, 64'(drain_idx), 64'(ei));
    chk({n, ".data"}, 64'(drain_data), 64'(edata));
    chk({n, ".q"}, {qo[7], qo[6], qo[5], qo[4], qo[3], qo[2], qo[1], qo[0]},
        {mq[7], mq[6], mq[5], mq[4], mq[3], mq[2], mq[1], mq[0]});
  endtask
  task automatic drive(input logic w, input logic [2:0] s, input logic [7:0] d, input logic r);
    wr = w;
    sel = s;
    for (int k = 0; k < 8; k++) lanes[k] = 8'hA0 | 8'(k);
    lanes[s] = d;
    drain_ready = r;
    @(posedge clk);
    if (w) mq[s] = d;
    #1;
  endtask
  task automatic do_reset(input string n);
    #2 rst = 1'b1;
    for (int k = 0; k < 8; k++) mq[k] = 8'h00;
    #1 check(n, 8'h00, 1'b0, 3'd0, 8'h00);
    rst = 1'b0;
  endtask
  initial begin
    for (int k = 0; k < 8; k++) begin
      lanes[k] = 8'h00;
      mq[k] = 8'h00;
    end
    tv[0]  = '{0, 1, 3, 8'h07, 1, 8'h08, 0, 3'd0, 8'h00};
    tv[1]  = '{0, 0, 0, 8'h00, 1, 8'h00, 1, 3'd3, 8'h07};
    tv[2]  = '{0, 0, 0, 8'h00, 1, 8'h00, 0, 3'd3, 8'h07};
    tv[3]  = '{1, 1, 0, 8'h0A, 0, 8'h01, 0, 3'd0, 8'h00};
    tv[4]  = '{0, 1, 6, 8'h60, 0, 8'h40, 1, 3'd0, 8'h0A};
    tv[5]  = '{0, 1, 1, 8'h10, 0, 8'h42, 1, 3'd0, 8'h0A};
    tv[6]  = '{0, 1, 7, 8'h70, 0, 8'hC2, 1, 3'd0, 8'h0A};
    tv[7]  = '{0, 0, 0, 8'h00, 1, 8'hC2, 0, 3'd0, 8'h0A};
    tv[8]  = '{0, 0, 0, 8'h00, 1, 8'hC0, 1, 3'd1, 8'h10};
    tv[9]  = '{0, 0, 0, 8'h00, 1, 8'hC0, 0, 3'd1, 8'h10};
    tv[10] = '{0, 0, 0, 8'h00, 1, 8'h80, 1, 3'd6, 8'h60};
    tv[11] = '{0, 1, 0, 8'h0B, 0, 8'h81, 1, 3'd6, 8'h60};
    tv[12] = '{0, 0, 0, 8'h00, 1, 8'h81, 0, 3'd6, 8'h60};
    tv[13] = '{0, 0, 0, 8'h00, 1, 8'h01, 1, 3'd7, 8'h70};
    tv[14] = '{0, 0, 0, 8'h00, 1, 8'h01, 0, 3'd7, 8'h70};
    tv[15] = '{0, 0, 0, 8'h00, 1, 8'h00, 1, 3'd0, 8'h0B};
    tv[16] = '{0, 0, 0, 8'h00, 1, 8'h00, 0, 3'd0, 8'h0B};
    #1 rst = 1'b1;
    #1 check("reset", 8'h00, 1'b0, 3'd0, 8'h00);
    #6 rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (tv[i].rb) do_reset($sformatf("vec%0d.rst", i));
      drive(tv[i].w, tv[i].s, tv[i].d, tv[i].r);
      check($sformatf("vec%0d", i), tv[i].ed, tv[i].ev, tv[i].ei, tv[i].edata);
    end
    do_reset("bp.rst");
    drive(1, 2, 8'h22, 0); check("bp.wr", 8'h04, 0, 3'd0, 8'h00);
    drive(0, 0, 8'h00, 0); check("bp.pres", 8'h00, 1, 3'd2, 8'h22);
    drive(1, 2, 8'h99, 0); check("bp.wr99", 8'h04, 1, 3'd2, 8'h22);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 8'h00, 0);
      check($sformatf("bp.hold%0d", i), 8'h04, 1, 3'd2, 8'h22);
    end
    drive(0, 0, 8'h00, 1); check("bp.xfer", 8'h04, 0, 3'd2, 8'h22);
    drive(0, 0, 8'h00, 1); check("bp.second", 8'h00, 1, 3'd2, 8'h99);
    drive(0, 0, 8'h00, 1); check("bp.xfer2", 8'h00, 0, 3'd2, 8'h99);
    do_reset("col.rst");
    drive(1, 5, 8'h11, 0); check("col.wr", 8'h20, 0, 3'd0, 8'h00);
    drive(1, 5, 8'h55, 0); check("col.same", 8'h20, 1, 3'd5, 8'h11);
    drive(0, 0, 8'h00, 1); check("col.xfer", 8'h20, 0, 3'd5, 8'h11);
    drive(0, 0, 8'h00, 1); check("col.later", 8'h00, 1, 3'd5, 8'h55);
    drive(0, 0, 8'h00, 1); check("col.xfer2", 8'h00, 0, 3'd5, 8'h55);
    drive(1, 3, 8'h33, 0); check("ar.wr", 8'h08, 0, 3'd5, 8'h55);
    drive(0, 0, 8'h00, 0); check("ar.pres", 8'h00, 1, 3'd3, 8'h33);
    do_reset("ar.async");
    drive(1, 4, 8'h44, 1); check("ar.wr4", 8'h10, 0, 3'd0, 8'h00);
    drive(0, 0, 8'h00, 1); check("ar.pres4", 8'h00, 1, 3'd4, 8'h44);
    drive(0, 0, 8'h00, 1); check("ar.xfer4", 8'h00, 0, 3'd4, 8'h44);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
